// File: rtl/beta_alu_issue.sv
// Beta ALU operand-issue / writeback stage: decodes one OP/OPC instruction at a time,
// presents registered ALUFN/A/B to an external ALU and retires Y into a 32x32 register file.
module beta_alu_issue #(
  parameter int ALU_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [5:0]  ALUFN,
  output logic [31:0] A,
  output logic [31:0] B,
  input  logic [31:0] Y,
  output logic        wb_valid,
  output logic [4:0]  wb_rc,
  output logic [31:0] wb_data,
  output logic        illegal,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  lat_cnt;
  logic [4:0]  rc_q;
  logic [31:0] rf [32];

  logic [5:0]  opcode;
  logic [4:0]  f_rc;
  logic [4:0]  f_ra;
  logic [4:0]  f_rb;
  logic [31:0] lit_sext;
  logic [31:0] ra_val;
  logic [31:0] rb_val;
  logic        fn_legal;
  logic        op_legal;
  logic        accept;
  logic        exec_done;

  assign opcode   = instr[31:26];
  assign f_rc     = instr[25:21];
  assign f_ra     = instr[20:16];
  assign f_rb     = instr[15:11];
  assign lit_sext = {{16{instr[15]}}, instr[15:0]};

  // R31 is hardwired to zero on every read port, independent of array contents.
  assign ra_val   = (f_ra == 5'd31) ? '0 : rf[f_ra];
  assign rb_val   = (f_rb == 5'd31) ? '0 : rf[f_rb];
  assign dbg_data = (dbg_addr == 5'd31) ? '0 : rf[dbg_addr];

  always_comb begin
    // NOTE: assign a default before the case so no path can infer a latch.
    fn_legal = 1'b0;
    case (opcode[3:0])
      4'h0, 4'h1, 4'h4, 4'h5, 4'h6,
      4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE: fn_legal = 1'b1;
      default:                                 fn_legal = 1'b0;
    endcase
  end

  assign op_legal  = opcode[5] & fn_legal;
  assign accept    = instr_valid & instr_ready;
  assign exec_done = (state == EXEC) && (lat_cnt == 3'(ALU_LATENCY));

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && op_legal) state_nxt = EXEC;
      EXEC:    if (exec_done)          state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    instr_ready = (state == IDLE);
    wb_valid    = (state == WB);
  end

  // Operand issue, latency counting and result capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ALUFN   <= '0;
      A       <= '0;
      B       <= '0;
      wb_rc   <= '0;
      wb_data <= '0;
      illegal <= 1'b0;
      lat_cnt <= '0;
      rc_q    <= '0;
    end else begin
      illegal <= accept & ~op_legal;
      if (accept && op_legal) begin
        ALUFN   <= {2'b10, opcode[3:0]};
        A       <= ra_val;
        B       <= opcode[4] ? lit_sext : rb_val;
        lat_cnt <= '0;
        rc_q    <= f_rc;
      end else if (state == EXEC) begin
        lat_cnt <= lat_cnt + 3'd1;
      end
      if (exec_done) begin
        wb_data <= Y;
        wb_rc   <= rc_q;
      end
    end
  end

  // Register file write port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: every entry must read zero after reset, so the array is resettable flops, not a RAM macro.
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_valid && (wb_rc != 5'd31)) begin
      rf[wb_rc] <= wb_data;
    end
  end

endmodule

// File: tb/tb_beta_alu_issue.sv
// Self-checking bench for beta_alu_issue: behavioural ALU models drive Y, and a
// register-file reference model predicts every writeback and debug read.
module tb_beta_alu_issue;

  localparam int L_MAIN = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, iv, ready, wbv, ill;
  logic [31:0] instr, a, b, y, wbd, dbgd;
  logic [5:0]  alufn;
  logic [4:0]  wbrc, dbg_addr;

  logic        iv0, rdy0, wbv0, ill0;
  logic [31:0] a0, b0, y0, wbd0, dbgd0;
  logic [5:0]  alufn0;
  logic [4:0]  wbrc0;

  logic        iv3, rdy3, wbv3, ill3;
  logic [31:0] a3, b3, y3, wbd3, dbgd3;
  logic [5:0]  alufn3;
  logic [4:0]  wbrc3;
  logic [31:0] p3 [3];

  int          passed = 0;
  int          total  = 0;
  logic [31:0] ref_rf [32];

  beta_alu_issue #(.ALU_LATENCY(L_MAIN)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(iv), .instr_ready(ready), .instr(instr),
    .ALUFN(alufn), .A(a), .B(b), .Y(y), .wb_valid(wbv), .wb_rc(wbrc), .wb_data(wbd),
    .illegal(ill), .dbg_addr(dbg_addr), .dbg_data(dbgd)
  );

  beta_alu_issue #(.ALU_LATENCY(0)) dut_l0 (
    .clk(clk), .rst_n(rst_n), .instr_valid(iv0), .instr_ready(rdy0), .instr(instr),
    .ALUFN(alufn0), .A(a0), .B(b0), .Y(y0), .wb_valid(wbv0), .wb_rc(wbrc0), .wb_data(wbd0),
    .illegal(ill0), .dbg_addr(dbg_addr), .dbg_data(dbgd0)
  );

  beta_alu_issue #(.ALU_LATENCY(3)) dut_l3 (
    .clk(clk), .rst_n(rst_n), .instr_valid(iv3), .instr_ready(rdy3), .instr(instr),
    .ALUFN(alufn3), .A(a3), .B(b3), .Y(y3), .wb_valid(wbv3), .wb_rc(wbrc3), .wb_data(wbd3),
    .illegal(ill3), .dbg_addr(dbg_addr), .dbg_data(dbgd3)
  );

  function automatic logic [31:0] alu_f(input logic [5:0] fn, input logic [31:0] x,
                                        input logic [31:0] z);
    case (fn[3:0])
      4'h0:    alu_f = x + z;
      4'h1:    alu_f = x - z;
      4'h4:    alu_f = (x == z) ? 32'd1 : 32'd0;
      4'h5:    alu_f = ($signed(x) < $signed(z)) ? 32'd1 : 32'd0;
      4'h6:    alu_f = ($signed(x) <= $signed(z)) ? 32'd1 : 32'd0;
      4'h8:    alu_f = x & z;
      4'h9:    alu_f = x | z;
      4'hA:    alu_f = x ^ z;
      4'hB:    alu_f = ~(x ^ z);
      4'hC:    alu_f = x << z[4:0];
      4'hD:    alu_f = x >> z[4:0];
      4'hE:    alu_f = $unsigned($signed(x) >>> z[4:0]);
      default: alu_f = 32'd0;
    endcase
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    is_legal = (op[5:4] == 2'b10 || op[5:4] == 2'b11) &&
               (op[3:0] inside {4'h0, 4'h1, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9,
                                4'hA, 4'hB, 4'hC, 4'hD, 4'hE});
  endfunction

  // ALU models: latency 1 (main), 0 and 3 (extra instances)
  always @(posedge clk) y <= alu_f(alufn, a, b);
  assign y0 = alu_f(alufn0, a0, b0);
  always @(posedge clk) begin
    p3[0] <= alu_f(alufn3, a3, b3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign y3 = p3[2];

  task automatic sweep_rf(input string nm);
    int bad;
    bad = 0;
    for (int r = 0; r < 32; r++) begin
      dbg_addr = 5'(r);
      @(negedge clk);
      if (dbgd !== ref_rf[r]) begin
        bad++;
        $display("FAIL %s: R%0d reads %h expected %h", nm, r, dbgd, ref_rf[r]);
      end
    end
    total++;
    if (bad == 0) passed++;
    @(posedge clk); #1;
  endtask

  task automatic run_op(input logic [31:0] ins, input string nm, output logic [31:0] got);
    logic [5:0]  op, exp_fn;
    logic [4:0]  rc, ra, rb;
    logic [31:0] exp_a, exp_b, exp_y;
    int          n, cyc;
    bit          stable;
    op     = ins[31:26];
    rc     = ins[25:21];
    ra     = ins[20:16];
    rb     = ins[15:11];
    exp_fn = {2'b10, op[3:0]};
    exp_a  = ref_rf[ra];
    exp_b  = op[4] ? {{16{ins[15]}}, ins[15:0]} : ref_rf[rb];
    exp_y  = alu_f(exp_fn, exp_a, exp_b);
    instr  = ins;
    iv     = 1'b1;
    n      = 0;
    while (ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    total++;
    if (n >= 20) $display("FAIL %s: instr_ready never 1 (timeout %0d cycles)", nm, n);
    else passed++;
    @(posedge clk); #1;
    iv     = 1'b0;
    instr  = $urandom;
    cyc    = 0;
    stable = 1'b1;
    while (wbv !== 1'b1 && cyc < 20) begin
      if (alufn !== exp_fn || a !== exp_a || b !== exp_b || ready !== 1'b0) stable = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    got = wbd;
    total++;
    if (!stable) $display("FAIL %s: exec operands ALUFN=%b A=%h B=%h expected %b %h %h", nm,
                          alufn, a, b, exp_fn, exp_a, exp_b);
    else passed++;
    total++;
    if (cyc != L_MAIN + 1) $display("FAIL %s: latency got %0d expected %0d", nm, cyc, L_MAIN + 1);
    else passed++;
    total++;
    if (wbrc !== rc) $display("FAIL %s: wb_rc got %0d expected %0d", nm, wbrc, rc);
    else passed++;
    total++;
    if (wbd !== exp_y) $display("FAIL %s: wb_data got %h expected %h", nm, wbd, exp_y);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (wbv !== 1'b0 || ready !== 1'b1)
      $display("FAIL %s: after wb wb_valid=%b instr_ready=%b expected 0 1", nm, wbv, ready);
    else passed++;
    if (rc != 5'd31) ref_rf[rc] = exp_y;
    dbg_addr = rc;
    #1;
    total++;
    if (dbgd !== ref_rf[rc]) $display("FAIL %s: dbg R%0d got %h expected %h", nm, rc, dbgd, ref_rf[rc]);
    else passed++;
  endtask

  task automatic run_illegal(input logic [31:0] ins, input string nm);
    logic [5:0]  fn_prev;
    logic [31:0] a_prev, b_prev;
    int          wb_seen;
    fn_prev = alufn;
    a_prev  = a;
    b_prev  = b;
    instr   = ins;
    iv      = 1'b1;
    @(posedge clk); #1;
    iv      = 1'b0;
    total++;
    if (ill !== 1'b1 || ready !== 1'b1)
      $display("FAIL %s: illegal=%b instr_ready=%b expected 1 1", nm, ill, ready);
    else passed++;
    total++;
    if (alufn !== fn_prev || a !== a_prev || b !== b_prev)
      $display("FAIL %s: operands changed to %b %h %h expected %b %h %h", nm, alufn, a, b,
               fn_prev, a_prev, b_prev);
    else passed++;
    wb_seen = (wbv === 1'b1) ? 1 : 0;
    @(posedge clk); #1;
    total++;
    if (ill !== 1'b0) $display("FAIL %s: illegal still %b expected 0", nm, ill);
    else passed++;
    repeat (3) begin
      if (wbv === 1'b1) wb_seen++;
      @(posedge clk); #1;
    end
    total++;
    if (wb_seen != 0) $display("FAIL %s: wb_valid pulses %0d expected 0", nm, wb_seen);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (alufn !== 6'd0 || a !== 32'd0 || b !== 32'd0 || wbv !== 1'b0 || wbrc !== 5'd0 ||
        wbd !== 32'd0 || ill !== 1'b0 || ready !== 1'b1)
      $display("FAIL reset_outputs: ALUFN=%h A=%h B=%h wbv=%b rc=%h wbd=%h ill=%b rdy=%b expected all 0, rdy 1",
               alufn, a, b, wbv, wbrc, wbd, ill, ready);
    else passed++;
    sweep_rf("reset_rf");
  endtask

  task automatic test_plan_ops();
    logic [31:0] got;
    run_op(32'hC03F000F, "addc_r1_15", got);
    total++;
    if (got !== 32'd15) $display("FAIL addc_r1_15: got %h expected 0000000f", got); else passed++;
    run_op({6'h30, 5'd2, 5'd31, 16'd13}, "addc_r2_13", got);
    total++;
    if (got !== 32'd13) $display("FAIL addc_r2_13: got %h expected 0000000d", got); else passed++;
    dbg_addr = 5'd1;
    #1;
    total++;
    if (dbgd !== 32'd15) $display("FAIL dbg_r1: got %h expected 0000000f", dbgd); else passed++;
    run_op({6'h30, 5'd1, 5'd31, 16'd13}, "addc_r1_13", got);
    run_op({6'h24, 5'd3, 5'd1, 5'd2, 11'd0}, "cmpeq_eq", got);
    total++;
    if (got !== 32'd1) $display("FAIL cmpeq_eq: got %h expected 1", got); else passed++;
    run_op({6'h30, 5'd1, 5'd31, 16'd15}, "addc_r1_15b", got);
    run_op({6'h24, 5'd3, 5'd1, 5'd2, 11'd0}, "cmpeq_ne", got);
    total++;
    if (got !== 32'd0) $display("FAIL cmpeq_ne: got %h expected 0", got); else passed++;
    run_op({6'h31, 5'd4, 5'd31, 16'd16}, "subc_r4", got);
    total++;
    if (got !== 32'hFFFFFFF0) $display("FAIL subc_r4: got %h expected fffffff0", got); else passed++;
    run_op({6'h3E, 5'd5, 5'd4, 16'd4}, "srac_r5", got);
    total++;
    if (got !== 32'hFFFFFFFF) $display("FAIL srac_r5: got %h expected ffffffff", got); else passed++;
    run_op({6'h3C, 5'd6, 5'd1, 16'd4}, "shlc_r6", got);
    total++;
    if (got !== 32'd240) $display("FAIL shlc_r6: got %h expected 000000f0", got); else passed++;
  endtask

  task automatic test_illegal();
    run_illegal({6'h22, 5'd1, 5'd2, 16'h1234}, "illegal_22");
    run_illegal({6'h00, 5'd2, 5'd1, 16'h0005}, "illegal_00");
    sweep_rf("illegal_rf");
  endtask

  task automatic test_r31();
    logic [31:0] got;
    run_op({6'h30, 5'd31, 5'd31, 16'd5}, "addc_r31", got);
    total++;
    if (got !== 32'd5) $display("FAIL addc_r31: wb_data got %h expected 5", got); else passed++;
  endtask

  task automatic test_hold_valid();
    int pulses, early;
    instr  = {6'h30, 5'd7, 5'd31, 16'd9};
    iv     = 1'b1;
    @(posedge clk); #1;
    pulses = 0;
    early  = 0;
    for (int k = 0; k < L_MAIN + 2; k++) begin
      if (ready !== 1'b0) early++;
      if (wbv === 1'b1) pulses++;
      @(posedge clk); #1;
    end
    total++;
    if (early != 0 || ready !== 1'b1)
      $display("FAIL hold_ready: busy-cycle ready count %0d, final ready %b expected 0, 1", early, ready);
    else passed++;
    iv = 1'b0;
    repeat (6) begin
      if (wbv === 1'b1) pulses++;
      @(posedge clk); #1;
    end
    total++;
    if (pulses != 1) $display("FAIL hold_single: wb_valid pulses %0d expected 1", pulses);
    else passed++;
    ref_rf[7] = 32'd9;
    dbg_addr  = 5'd7;
    #1;
    total++;
    if (dbgd !== 32'd9) $display("FAIL hold_r7: got %h expected 9", dbgd); else passed++;
  endtask

  task automatic test_latency(input int which);
    logic [15:0] lit;
    logic [31:0] sx, exp_v, got;
    logic [31:0] ins [2];
    int          n, cyc;
    lit    = 16'($urandom);
    sx     = {{16{lit[15]}}, lit};
    ins[0] = {6'h30, 5'd1, 5'd31, lit};
    ins[1] = {6'h20, 5'd2, 5'd1, 5'd1, 11'd0};
    for (int k = 0; k < 2; k++) begin
      exp_v = (k == 0) ? sx : sx + sx;
      instr = ins[k];
      if (which == 0) iv0 = 1'b1;
      else            iv3 = 1'b1;
      n = 0;
      while (((which == 0) ? rdy0 : rdy3) !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      iv0 = 1'b0;
      iv3 = 1'b0;
      cyc = 0;
      while (((which == 0) ? wbv0 : wbv3) !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
      got = (which == 0) ? wbd0 : wbd3;
      total++;
      if (cyc != which + 1) $display("FAIL latency_l%0d: got %0d cycles expected %0d", which, cyc, which + 1);
      else passed++;
      total++;
      if (got !== exp_v) $display("FAIL data_l%0d: got %h expected %h", which, got, exp_v);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random(input int count);
    logic [3:0]  fns [12];
    logic [5:0]  op;
    logic [4:0]  rc, ra, rb;
    logic [31:0] ins, got;
    int          sel;
    fns = '{4'h0, 4'h1, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE};
    for (int i = 0; i < count; i++) begin
      if ($urandom_range(7) == 0) begin
        do op = 6'($urandom); while (is_legal(op));
        run_illegal({op, 26'($urandom)}, "rand_illegal");
      end else begin
        sel = $urandom_range(9);
        rc  = (sel == 9) ? 5'd31 : 5'(sel + 1);
        sel = $urandom_range(9);
        ra  = (sel == 9) ? 5'd31 : 5'(sel);
        sel = $urandom_range(9);
        rb  = (sel == 9) ? 5'd31 : 5'(sel);
        op  = {1'b1, 1'($urandom), fns[$urandom_range(11)]};
        ins = {op, rc, ra, rb, 11'($urandom)};
        run_op(ins, "rand_op", got);
      end
    end
    sweep_rf("rand_rf");
  endtask

  task automatic test_reset_mid();
    logic [31:0] got;
    int          wb_seen;
    run_op({6'h30, 5'd1, 5'd31, 16'd55}, "pre_reset_r1", got);
    instr = {6'h30, 5'd1, 5'd31, 16'd77};
    iv    = 1'b1;
    @(posedge clk); #1;
    iv    = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    total++;
    if (alufn !== 6'd0 || a !== 32'd0 || b !== 32'd0 || wbv !== 1'b0 || wbrc !== 5'd0 ||
        wbd !== 32'd0 || ill !== 1'b0 || ready !== 1'b1)
      $display("FAIL midreset_outputs: ALUFN=%h A=%h B=%h wbv=%b rc=%h wbd=%h ill=%b rdy=%b expected all 0, rdy 1",
               alufn, a, b, wbv, wbrc, wbd, ill, ready);
    else passed++;
    wb_seen = 0;
    repeat (5) begin
      if (wbv === 1'b1) wb_seen++;
      @(posedge clk); #1;
    end
    total++;
    if (wb_seen != 0) $display("FAIL midreset_wb: wb_valid pulses %0d expected 0", wb_seen);
    else passed++;
    for (int r = 0; r < 32; r++) ref_rf[r] = '0;
    sweep_rf("midreset_rf");
  endtask

  initial begin
    rst_n    = 1'b0;
    iv       = 1'b0;
    iv0      = 1'b0;
    iv3      = 1'b0;
    instr    = '0;
    dbg_addr = '0;
    for (int r = 0; r < 32; r++) ref_rf[r] = '0;
    test_reset();
    test_plan_ops();
    test_illegal();
    test_r31();
    test_hold_valid();
    test_latency(0);
    test_latency(3);
    test_random(40);
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
